// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial accumulator: operation encodings and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_byte_slice.sv
// 8-bit full adder slice; the accumulator reuses a single instance for every byte.
module alu_byte_slice (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CIN,
    output logic [7:0] SUM,
    output logic       COUT
);

    logic [8:0] total;

    assign total = {1'b0, A} + {1'b0, B} + {8'd0, CIN};
    assign SUM   = total[7:0];
    assign COUT  = total[8];

endmodule

// File: rtl/alu_accumulator.sv
// Byte-serial add/sub/load/clear accumulator, one byte per cycle, LSB first.
// Define ALU_ACC_SAT_EN to clamp signed overflow instead of wrapping.
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int BYTES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [1:0]           OP,
    input  logic [8*BYTES-1:0]   OPERAND,
    output logic [8*BYTES-1:0]   ACC,
    output logic                 OUT_VALID,
    output logic                 C_OUT,
    output logic                 OVERFLOW,
    output logic                 ZERO
);

    localparam int W    = 8 * BYTES;
    localparam int IDXW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(BYTES - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    op_e             op_q, op_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;

    logic            arith;
    logic [W-1:0]    summand;
    logic [7:0]      a_byte, b_byte, sum_byte;
    logic            cout_byte;
    logic [W-1:0]    res_full, result;
    logic            a_msb, raw_ovf;

    // Load and clear run through the same adder with the accumulator side forced to zero.
    assign arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign summand = (op_q == OP_SUB) ? ~opnd_q :
                     (op_q == OP_CLR) ? '0 : opnd_q;
    assign a_byte  = arith ? acc_q[idx_q*8 +: 8] : 8'd0;
    assign b_byte  = summand[idx_q*8 +: 8];

    alu_byte_slice u_slice (
        .A    (a_byte),
        .B    (b_byte),
        .CIN  (carry_q),
        .SUM  (sum_byte),
        .COUT (cout_byte)
    );

    always_comb begin
        res_full = res_q;
        res_full[idx_q*8 +: 8] = sum_byte;
    end

    assign a_msb   = arith ? acc_q[W-1] : 1'b0;
    assign raw_ovf = arith && (a_msb == summand[W-1]) && (res_full[W-1] != a_msb);

`ifdef ALU_ACC_SAT_EN
    // Both operands share a sign on overflow, so that sign picks the clamp direction.
    assign result = !raw_ovf ? res_full :
                    a_msb    ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    assign result = res_full;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        acc_d   = acc_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    op_d    = op_e'(OP);
                    opnd_d  = OPERAND;
                    idx_d   = '0;
                    carry_d = (OP == OP_SUB);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = res_full;
                carry_d = cout_byte;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    acc_d   = result;
                    cout_d  = arith ? cout_byte : 1'b0;
                    ovf_d   = raw_ovf;
                    zero_d  = (result == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= OP_ADD;
            opnd_q  <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_DONE);
    assign ACC       = acc_q;
    assign C_OUT     = cout_q;
    assign OVERFLOW  = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed-vector bench for alu_accumulator at BYTES=2; honours ALU_ACC_SAT_EN.
module tb_alu_accumulator;
    import alu_pkg::*;

    localparam int BYTES = 2;
    localparam int W     = 8 * BYTES;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [1:0]   OP;
    logic [W-1:0] OPERAND;
    logic [W-1:0] ACC;
    logic         OUT_VALID, C_OUT, OVERFLOW, ZERO;

    int n_cmp = 0;
    int n_bad = 0;

    alu_accumulator #(.BYTES(BYTES)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP        (OP),
        .OPERAND   (OPERAND),
        .ACC       (ACC),
        .OUT_VALID (OUT_VALID),
        .C_OUT     (C_OUT),
        .OVERFLOW  (OVERFLOW),
        .ZERO      (ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command; the accept cycle is cycle 0 and OUT_VALID must appear in cycle 3.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] opnd);
        int n;
        @(negedge CLK);
        IN_VALID = 1'b1;
        OP       = op;
        OPERAND  = opnd;
        n = 0;
        while (!IN_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_ready"}, IN_READY, 1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        n = 1;
        while (!OUT_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_lat"}, n, 3);
        @(negedge CLK);
        chk({tag, "_pulse"}, OUT_VALID, 0);
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] acc, input logic c,
                           input logic v, input logic z);
        chk({tag, "_acc"}, ACC, acc);
        chk({tag, "_c"}, C_OUT, c);
        chk({tag, "_v"}, OVERFLOW, v);
        chk({tag, "_z"}, ZERO, z);
    endtask

    initial begin
        int na, np, a0, a1, p0, p1, nbusy;
        RST = 1'b1; IN_VALID = 1'b0; OP = OP_ADD; OPERAND = '0;
        repeat (2) @(negedge CLK);
        chk_res("rst", 16'h0000, 0, 0, 1);
        chk("rst_ov", OUT_VALID, 0);
        chk("rst_rdy", IN_READY, 1);
        RST = 1'b0;

        do_cmd("ld00ff", OP_LOAD, 16'h00FF);
        chk_res("ld00ff", 16'h00FF, 0, 0, 0);
        do_cmd("add1", OP_ADD, 16'h0001);
        chk_res("add1", 16'h0100, 0, 0, 0);

        do_cmd("ld7fff", OP_LOAD, 16'h7FFF);
        do_cmd("posovf", OP_ADD, 16'h0001);
`ifdef ALU_ACC_SAT_EN
        chk_res("posovf", 16'h7FFF, 0, 1, 0);
`else
        chk_res("posovf", 16'h8000, 0, 1, 0);
`endif

        do_cmd("clr", OP_CLR, 16'hABCD);
        chk_res("clr", 16'h0000, 0, 0, 1);
        do_cmd("sub1", OP_SUB, 16'h0001);
        chk_res("sub1", 16'hFFFF, 0, 0, 0);
        do_cmd("subffff", OP_SUB, 16'hFFFF);
        chk_res("subffff", 16'h0000, 1, 0, 1);

        do_cmd("ld8000", OP_LOAD, 16'h8000);
        do_cmd("negovf", OP_SUB, 16'h0001);
`ifdef ALU_ACC_SAT_EN
        chk_res("negovf", 16'h8000, 1, 1, 0);
`else
        chk_res("negovf", 16'h7FFF, 1, 1, 0);
`endif

        // Back-to-back: IN_VALID held across two adds of 3.
        do_cmd("ld0", OP_LOAD, 16'h0000);
        na = 0; np = 0; a0 = -1; a1 = -1; p0 = -1; p1 = -1; nbusy = 0;
        @(negedge CLK);
        IN_VALID = 1'b1; OP = OP_ADD; OPERAND = 16'h0003;
        for (int c = 0; c < 12; c++) begin
            if (IN_READY && IN_VALID) begin
                if (na == 0) a0 = c; else a1 = c;
                na++;
            end
            if (OUT_VALID) begin
                if (np == 0) p0 = c; else p1 = c;
                np++;
            end
            if (!IN_READY && c < 8) nbusy++;
            @(negedge CLK);
            if (na == 2) IN_VALID = 1'b0;
        end
        chk("b2b_acc0", a0, 0);
        chk("b2b_acc1", a1, 4);
        chk("b2b_npulse", np, 2);
        chk("b2b_p0", p0, 3);
        chk("b2b_p1", p1, 7);
        chk("b2b_busy", nbusy, 6);
        chk("b2b_res", ACC, 16'h0006);

        // Reset during the second EXEC cycle aborts the add silently.
        do_cmd("ld1234", OP_LOAD, 16'h1234);
        @(negedge CLK);
        IN_VALID = 1'b1; OP = OP_ADD; OPERAND = 16'h0001;
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("abort_exec1", IN_READY, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_idle", IN_READY, 1);
        chk("abort_ov", OUT_VALID, 0);
        chk_res("abort", 16'h0000, 0, 0, 1);
        np = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (OUT_VALID) np++;
        end
        chk("abort_nopulse", np, 0);
        do_cmd("post", OP_ADD, 16'h0005);
        chk_res("post", 16'h0005, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
